// File: rtl/mult_div_unit_if.sv
// Bus bundle for the iterative multiply/divide unit.
// Handshake: the unit accepts a request on any rising edge where start=1 and
// it is idle (busy=0); start/op are ignored while busy=1. The result is in
// hi/lo when done=1, which lasts exactly one cycle. div_by_zero is valid only
// while done=1. hi_we/lo_we take effect only while busy=0.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    // Requester side (datapath control or testbench)
    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo, dbg_state
    );

    // Unit side
    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo, dbg_state
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. 32 RUN cycles, one FIX cycle.
module mult_div_unit (
    input  logic              clk,
    input  logic              rst,
    mult_div_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic        sign_quo_q;   // product / quotient must be negated
    logic        sign_rem_q;   // remainder must be negated (dividend sign)
    logic        bzero_q;      // divisor was zero at start
    logic [31:0] opa_q;        // raw operand_a, returned in HI on divide by zero
    logic [31:0] mcand_q;      // multiplicand (multiply) or divisor (divide)
    logic [63:0] acc_q;        // {partial hi, shifting lo} accumulator
    logic [31:0] hi_q, lo_q;
    logic        done_q, dbz_q;

    logic        start_fire;
    logic        is_div, is_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] res_hi, res_lo;

    // Operand conditioning at start: magnitudes for signed ops, raw otherwise
    always_comb begin
        start_fire = (state_q == S_IDLE) && bus.start;
        is_div     = bus.op[1];
        is_signed  = ~bus.op[0];
        a_neg      = is_signed & bus.operand_a[31];
        b_neg      = is_signed & bus.operand_b[31];
        a_mag      = a_neg ? (~bus.operand_a + 32'd1) : bus.operand_a;
        b_mag      = b_neg ? (~bus.operand_b + 32'd1) : bus.operand_b;
    end

    // One iteration step: shift-add multiply (LSB first) and restoring divide (MSB first)
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_trial = acc_q[63:31] - {1'b0, mcand_q};
        if (div_trial[32]) begin
            div_next = {acc_q[62:0], 1'b0};
        end else begin
            div_next = {div_trial[31:0], acc_q[30:0], 1'b1};
        end
    end

    // Sign fix-up and result selection for the FIX cycle
    always_comb begin
        prod_fix = sign_quo_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = sign_quo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = sign_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (!op_q[1]) begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end else if (bzero_q) begin
            res_hi = opa_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy        = (state_q == S_RUN) || (state_q == S_FIX);
        bus.dbg_state   = state_q;
        bus.done        = done_q;
        bus.div_by_zero = dbz_q;
        bus.hi          = hi_q;
        bus.lo          = lo_q;
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 5'd0;
            op_q       <= 2'd0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            bzero_q    <= 1'b0;
            opa_q      <= 32'd0;
            mcand_q    <= 32'd0;
            acc_q      <= 64'd0;
        end else if (start_fire) begin
            cnt_q      <= 5'd0;
            op_q       <= bus.op;
            sign_quo_q <= a_neg ^ b_neg;
            sign_rem_q <= a_neg;
            bzero_q    <= (bus.operand_b == 32'd0);
            opa_q      <= bus.operand_a;
            mcand_q    <= is_div ? b_mag : a_mag;
            acc_q      <= {32'd0, (is_div ? a_mag : b_mag)};
        end else if (state_q == S_RUN) begin
            cnt_q      <= cnt_q + 5'd1;
            acc_q      <= op_q[1] ? div_next : mul_next;
        end
    end

    // HI/LO: result write in FIX, MTHI/MTLO only in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (state_q == S_FIX) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
                dbz_q  <= op_q[1] & bzero_q;
            end else if (state_q == S_IDLE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the single-cycle MIPS datapath. It sits directly downstream of the general-purpose register file and takes `read_data1`/`read_data2` as operands for MULT, MULTU, DIV and DIVU. It computes the 64-bit product, or the quotient and remainder, over 32 iterations and holds the result in architectural HI/LO registers, which MFHI/MFLO read back into the register-file write path. MTHI/MTLO write HI/LO directly.

## Interface
No parameters. Width is fixed at 32 bits, iterations at 32.
- `clk` input 1: rising-edge clock shared with the register file.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `start` input 1: starts an operation; sampled only in IDLE.
- `op` input 2: operation select, sampled with `start`.
  - 00 = MULT
  - 01 = MULTU
  - 10 = DIV
  - 11 = DIVU
- `operand_a` input 32: rs value (multiplicand or dividend).
- `operand_b` input 32: rt value (multiplier or divisor).
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input 32: MTHI/MTLO data.
- `busy` output 1: operation in progress; high in RUN and FIX.
- `done` output 1: one-cycle pulse when HI/LO receive a result.
- `div_by_zero` output 1: valid with `done`; set when a DIV/DIVU had `operand_b == 0`.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **States:** IDLE, RUN, FIX.
  - IDLE → RUN when `start`=1.
  - RUN → FIX after 32 iterations; a 5-bit counter runs 0..31.
  - FIX → IDLE unconditionally.
- **At start:**
  - Latch `op`.
  - Latch operand magnitudes: for signed ops, take the two's-complement absolute value; for unsigned ops, use the operands raw.
  - Latch `neg_q` = sign(a) XOR sign(b) and `neg_r` = sign(a). Both are 0 for unsigned ops.
- **Multiply:** shift-add on a 64-bit accumulator, one multiplier bit per RUN cycle, LSB first.
- **Divide:** restoring division, one quotient bit per RUN cycle, MSB first. Uses a 33-bit trial subtract.
- **FIX (results are written in this cycle):**
  - Multiply: if `neg_q`, negate the 64-bit product. HI = bits [63:32], LO = bits [31:0].
  - Divide: LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r` (the remainder takes the dividend's sign, quotient truncates toward zero).
  - Divide with divisor 0 (both signednesses): HI = original `operand_a`, LO = 32'hFFFFFFFF, `div_by_zero` = 1.
  - `div_by_zero` is 0 for every multiply and for non-zero divisors.
- **Overflow:** DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No trap.
- **MTHI/MTLO:** `hi_we`/`lo_we` write `wdata` at the clock edge, only in IDLE. They are ignored while `busy`.
- **Simultaneous events in IDLE:** an MTHI/MTLO write together with `start` is performed. The operation result overwrites HI/LO later, in FIX.
- **Operand stability:** `start` and `op` are ignored while `busy`. Operands may change freely after the start edge.

## Timing
- **Reset values:** while `rst`=0, asynchronously: state = IDLE, `hi` = `lo` = 0, `busy` = `done` = `div_by_zero` = 0, counter and accumulators = 0. This holds mid-operation; the operation is abandoned.
- **Latency:** with `start` sampled at edge t:
  - RUN occupies edges t+1..t+32.
  - FIX writes HI/LO at edge t+33.
  - `done`=1 for exactly the cycle after t+33; `busy` is already 0 in that cycle.
- **`busy`:** 1 from after edge t to after edge t+33, i.e. 33 cycles.
- **Back-to-back:** a new `start` may be sampled in the `done` cycle, so the issue interval is 34 cycles.
- **Output timing:** `hi`/`lo` change only at a FIX edge, an IDLE write edge, or reset. They are registered outputs with no combinational path from the inputs.
- **`div_by_zero`:** registered at the FIX edge, cleared at the next edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001, `done` in the cycle after edge t+33, `busy` high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 and DIV 0xFFFFFFF0 / 0 → HI = operand_a, LO = 0xFFFFFFFF, `div_by_zero` = 1 with `done`. The next MULTU 2 × 3 completes with `div_by_zero` = 0.
- Idle `hi_we`/`wdata` = 0x12345678 → `hi` updates at the next edge. The same write while `busy`, plus a second `start` with different operands while `busy` → both ignored, result unchanged.
- Assert `rst` 10 cycles into a DIVU → all outputs 0 immediately, no `done`. After release, MULTU 6 × 7 → LO = 42, HI = 0 at nominal latency.
